// File: rtl/scan_chain_ctrl.sv
// Load/capture/unload sequencer for one serial scan chain with result compare.
// Define SCAN_CTRL_ABORT_EN to add the ABORT input (early termination, forced MISMATCH).
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic [CHAIN_LEN-1:0] EXP_IN,
    input  logic                 SCAN_IN,
`ifdef SCAN_CTRL_ABORT_EN
    input  logic                 ABORT,
`endif
    output logic                 SCAN_OUT,
    output logic                 SCAN_EN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CHAIN_LEN-1:0] RESULT,
    output logic                 MISMATCH
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_FINISH
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [CHAIN_LEN-1:0] shreg, shreg_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] res_q, res_d;
    logic                 mism_q, mism_d;
    logic                 so_q, so_d;
    logic                 se_q, se_d;
    logic                 abort_req;

`ifdef SCAN_CTRL_ABORT_EN
    assign abort_req = ABORT;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            shreg  <= '0;
            exp_q  <= '0;
            res_q  <= '0;
            mism_q <= 1'b0;
            so_q   <= 1'b0;
            se_q   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            shreg  <= shreg_d;
            exp_q  <= exp_d;
            res_q  <= res_d;
            mism_q <= mism_d;
            so_q   <= so_d;
            se_q   <= se_d;
        end
    end

    // SCAN_OUT/SCAN_EN are computed one cycle ahead so the registered values line up with the state they serve.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shreg_d = shreg;
        exp_d   = exp_q;
        res_d   = res_q;
        mism_d  = mism_q;
        so_d    = 1'b0;
        se_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    shreg_d = {PAT_IN[CHAIN_LEN-2:0], 1'b0};
                    exp_d   = EXP_IN;
                    mism_d  = 1'b0;
                    so_d    = PAT_IN[CHAIN_LEN-1];
                    se_d    = 1'b1;
                end
            end
            S_LOAD: begin
                if (cnt == LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt + ONE;
                    so_d    = shreg[CHAIN_LEN-1];
                    shreg_d = {shreg[CHAIN_LEN-2:0], 1'b0};
                    se_d    = 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d = S_UNLOAD;
                cnt_d   = '0;
                se_d    = 1'b1;
            end
            S_UNLOAD: begin
                res_d = {res_q[CHAIN_LEN-2:0], SCAN_IN};
                if (cnt == LAST) begin
                    state_d = S_FINISH;
                    cnt_d   = '0;
                    mism_d  = (res_d != exp_q);
                end else begin
                    cnt_d = cnt + ONE;
                    se_d  = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides the terminal-count path; partial RESULT is held unshifted.
        if (abort_req && ((state == S_LOAD) || (state == S_CAPTURE) || (state == S_UNLOAD))) begin
            state_d = S_FINISH;
            cnt_d   = '0;
            res_d   = res_q;
            mism_d  = 1'b1;
            so_d    = 1'b0;
            se_d    = 1'b0;
        end
    end

    assign SCAN_OUT = so_q;
    assign SCAN_EN  = se_q;
    assign BUSY     = (state != S_IDLE);
    assign DONE     = (state == S_FINISH);
    assign RESULT   = res_q;
    assign MISMATCH = mism_q;

endmodule
